wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave port (10-bit word address [11:2], 32-bit data, 4-bit byte select) among NUM_MASTERS requesters.
- Sits between processor/DMA-side masters and a single register-file slave.
- The granted master owns the bus for as long as its cyc stays high, which allows locked multi-beat sequences.
- A watchdog aborts a hung transfer by returning err to the master.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err before abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock; all state on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*10  packed word addresses; master k at [10k+9:10k].
- m_sel_i  in  NUM_MASTERS*4  packed byte selects.
- m_dat_i  in  NUM_MASTERS*32  packed write data.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack, routed to the granted master only.
- m_err_o  out  NUM_MASTERS  err, routed to the granted master only (slave err or timeout).
- gnt_o  out  NUM_MASTERS  one-hot current grant.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  10  slave word address (bits [11:2]).
- s_sel_o  out  4  slave byte select.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE, gnt_o=0, watchdog count=0, last-grant pointer=NUM_MASTERS-1, so master 0 has first priority.
  - All s_* outputs, m_ack_o and m_err_o are 0.
- States: IDLE, OWN, TMO_ERR, DRAIN.
- IDLE:
  - If any m_cyc_i is high, pick the first requester scanning from (last+1) mod N upward with wrap.
  - Register it in gnt_o and enter OWN. Grant latency is 1 cycle after cyc is sampled.
  - s_cyc_o and s_stb_o stay 0 in IDLE.
  - A stray s_ack_i or s_err_i in IDLE is ignored.
- OWN:
  - Slave outputs are a combinational mux of the granted master: s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g], plus we/adr/sel/dat.
  - m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i; all other bits are 0.
  - m_dat_o = s_dat_i at all times.
  - Requests from other masters are ignored while g holds cyc.
  - When m_cyc_i[g]=0 is sampled: last=g, gnt_o=0, go to IDLE. A new grant is therefore issued no earlier than 2 cycles after release.
- Watchdog (OWN only):
  - Increments each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0.
  - Clears on ack, err, or stb low.
  - If the count reaches TIMEOUT (nonzero), go to TMO_ERR.
  - If ack/err arrives in the same cycle the count hits TIMEOUT, ack/err wins and no abort occurs.
- TMO_ERR (1 cycle):
  - s_cyc_o=0, s_stb_o=0, m_err_o[g]=1.
  - Go to DRAIN; if m_cyc_i[g] is already 0, go straight to IDLE with last=g.
- DRAIN:
  - s_cyc_o=0 and s_stb_o=0; a late s_ack_i is ignored.
  - Wait for m_cyc_i[g]=0, then last=g and go to IDLE.
- Fairness: a master that just released gets lowest priority next round. With all N requesting continuously, grants rotate 0,1,..,N-1,0.
- Counter width: $clog2(TIMEOUT+1), saturating; it never wraps.

Decomposition:
- Package wb_arb_pkg:
  - Constants WB_ADR_W=10, WB_SEL_W=4, WB_DAT_W=32.
  - typedef enum arb_state_e {IDLE, OWN, TMO_ERR, DRAIN}.
- Sub-module wb_rr_picker: purely combinational rotate-priority encoder.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, index.
- The arbiter holds the FSM, watchdog and muxes.

Test Plan:
- Single master 2 writes adr=0x010, dat=0xDEADBEEF, sel=0xF, slave acks after 2 wait states -> gnt_o=0001 one cycle after cyc; s_adr_o=0x010; m_ack_o[0] pulses once per beat; m_ack_o[3:1]=0.
- All 4 masters hold cyc, each does one read then drops cyc -> grant order 0,1,2,3,0; m_dat_o equals the slave's 0xA5A5_0000+k for master k.
- Master 2 locked for 5 beats while master 1 requests -> gnt_o stays 0100 for all 5 acks; 0010 is granted 2 cycles after m_cyc_i[2] falls.
- TIMEOUT=8, slave never acks master 3 -> m_err_o[3]=1 exactly on the 9th strobed cycle; s_cyc_o=0 from then; a late s_ack_i is not forwarded; returns to IDLE after master drops cyc.
- Slave s_err_i on the same cycle the count reaches TIMEOUT -> a single err pulse, no TMO_ERR, FSM stays in OWN.
- wb_rst_i asserted mid-beat in OWN -> gnt_o, s_cyc_o, s_stb_o go to 0 without waiting for a clock edge; after release, master 0 wins when 0 and 2 request simultaneously.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared Wishbone bus widths and arbiter FSM encoding.
package wb_arb_pkg;

  localparam int WB_ADR_W = 10;  // word address, bits [11:2] of the byte address
  localparam int WB_SEL_W = 4;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,     // no owner, waiting for any cyc
    OWN,      // granted master drives the slave port
    TMO_ERR,  // one-cycle err to the owner after a watchdog abort
    DRAIN     // slave cut off, waiting for the owner to drop cyc
  } arb_state_e;

endpackage

// File: rtl/wb_rr_picker.sv
// Rotating-priority encoder: picks the first requester after the last grant.
module wb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx
);

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    int k;
    // NOTE: every output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      k = int'(last) + off;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (req[IDX_W'(k)]) begin
        gnt = NUM_MASTERS'(1) << k;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, with a
// watchdog that aborts a stalled transfer by returning err to its owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  // Width still 1 when the watchdog is disabled so the register stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_e               state_q, state_d;
  logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         cnt_inc;
  logic [NUM_MASTERS-1:0]   pick_gnt;
  logic [IDX_W-1:0]         pick_idx;
  logic                     own;
  logic                     cyc_g;
  logic                     stb_g;
  logic                     stall;

  // Per-master views of the packed buses so the mux can index by grant.
  logic [WB_ADR_W-1:0] adr_a [NUM_MASTERS];
  logic [WB_SEL_W-1:0] sel_a [NUM_MASTERS];
  logic [WB_DAT_W-1:0] dat_a [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_a[k] = m_adr_i[k*WB_ADR_W +: WB_ADR_W];
    assign sel_a[k] = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
    assign dat_a[k] = m_dat_i[k*WB_DAT_W +: WB_DAT_W];
  end

  wb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign own     = (state_q == OWN);
  assign cyc_g   = m_cyc_i[idx_q];
  assign stb_g   = m_stb_i[idx_q];
  assign stall   = stb_g & ~s_ack_i & ~s_err_i;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State register plus grant, last-grant pointer and watchdog count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; blocking here would make results depend on statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant, hold while cyc stays high, watchdog abort.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = '0;
    if (state_q != IDLE && !cyc_g) begin
      // Owner released: it becomes lowest priority for the next round.
      state_d = IDLE;
      gnt_d   = '0;
      last_d  = idx_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            state_d = OWN;
            gnt_d   = pick_gnt;
            idx_d   = pick_idx;
          end
        end
        OWN: begin
          // An ack/err in the cycle the count would hit TIMEOUT clears stall.
          if (stall) begin
            cnt_d = cnt_inc;
            if (TIMEOUT != 0 && cnt_inc == TMO_VAL) begin
              state_d = TMO_ERR;
              cnt_d   = '0;
            end
          end
        end
        TMO_ERR: state_d = DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Route slave ack/err to the owner; an abort forces a single err cycle.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      OWN: begin
        m_ack_o = gnt_q & {NUM_MASTERS{s_ack_i}};
        m_err_o = gnt_q & {NUM_MASTERS{s_err_i}};
      end
      TMO_ERR: m_err_o = gnt_q;
      default: ;
    endcase
  end

  // The slave only sees the owner while in OWN; everything is zero otherwise.
  assign s_cyc_o = own & cyc_g;
  assign s_stb_o = own & stb_g;
  assign s_we_o  = own & m_we_i[idx_q];
  assign s_adr_o = own ? adr_a[idx_q] : '0;
  assign s_sel_o = own ? sel_a[idx_q] : '0;
  assign s_dat_o = own ? dat_a[idx_q] : '0;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (4 masters, watchdog of 8 cycles).
module tb_wb_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int VW  = 93;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*10-1:0] m_adr;
  logic [N*4-1:0]  m_sel;
  logic [N*32-1:0] m_wdat;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [9:0]      s_adr_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_dat_o, s_dat;
  logic            s_ack, s_err;
  logic [VW-1:0]   act_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_sel_i  (m_sel),
    .m_dat_i  (m_wdat),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .gnt_o    (gnt_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_sel_o  (s_sel_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err)
  );

  assign act_vec = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
                    m_ack_o, m_err_o, m_dat_o};

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the bus. aborted: slave cut off after a
  // timeout; err_cycle: the single cycle in which the abort err is shown.
  int mo_owner, mo_last, mo_stall;
  bit mo_aborted, mo_err_cycle;

  task automatic model_reset();
    mo_owner = -1; mo_last = N - 1; mo_stall = 0;
    mo_aborted = 0; mo_err_cycle = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else if (mo_owner < 0) begin
      for (int off = 1; off <= N; off++) begin
        int k = (mo_last + off) % N;
        if (m_cyc[k] && mo_owner < 0) mo_owner = k;
      end
      mo_stall = 0;
    end else if (!m_cyc[mo_owner]) begin
      mo_last = mo_owner; mo_owner = -1;
      mo_aborted = 0; mo_err_cycle = 0; mo_stall = 0;
    end else if (mo_aborted) begin
      mo_err_cycle = 0;
    end else if (m_stb[mo_owner] && !s_ack && !s_err) begin
      mo_stall++;
      if (mo_stall == TMO) begin
        mo_aborted = 1; mo_err_cycle = 1; mo_stall = 0;
      end
    end else begin
      mo_stall = 0;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g = '0, a = '0, e = '0;
    logic sc = 0, ss = 0, sw = 0;
    logic [9:0] sa = '0;
    logic [3:0] sl = '0;
    logic [31:0] sd = '0;
    if (mo_owner >= 0) begin
      g[mo_owner] = 1'b1;
      if (!mo_aborted) begin
        sc = m_cyc[mo_owner]; ss = m_stb[mo_owner]; sw = m_we[mo_owner];
        sa = m_adr[mo_owner*10 +: 10];
        sl = m_sel[mo_owner*4 +: 4];
        sd = m_wdat[mo_owner*32 +: 32];
        a[mo_owner] = s_ack; e[mo_owner] = s_err;
      end else if (mo_err_cycle) begin
        e[mo_owner] = 1'b1;
      end
    end
    return {g, sc, ss, sw, sa, sl, sd, a, e, s_dat};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive_idle();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_wdat = '0;
    s_ack = 0; s_err = 0; s_dat = '0;
  endtask

  task automatic set_master(input int k, input logic we, input logic [9:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
    m_we[k] = we;
    m_adr[k*10 +: 10] = adr;
    m_sel[k*4 +: 4] = sel;
    m_wdat[k*32 +: 32] = dat;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; m_cyc = '1; m_stb = '1; s_ack = 1; s_err = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, m_ack_o, m_err_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b s_cyc=%b s_stb=%b ack=%b err=%b, expected all zero",
                 i, gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_rotation();
    int order[$];
    int nacks = 0;
    bit [N-1:0] acked = '0, rearm = '0;
    logic [N-1:0] prev_g = '0;
    drive_idle();
    m_cyc = '1; m_stb = '1;
    for (int k = 0; k < N; k++) set_master(k, 1'b0, 10'(16 * k), 4'hF, 32'h0);
    for (int i = 0; i < 80 && nacks < 5; i++) begin
      for (int k = 0; k < N; k++) begin
        if (acked[k]) begin
          m_cyc[k] = 0; m_stb[k] = 0; rearm[k] = 1;
        end else if (rearm[k]) begin
          m_cyc[k] = 1; m_stb[k] = 1; rearm[k] = 0;
        end
      end
      acked = '0;
      s_ack = 0; s_dat = '0;
      for (int k = 0; k < N; k++)
        if (gnt_o[k] && m_stb[k]) begin s_ack = 1; s_dat = 32'hA5A5_0000 + k; end
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (gnt_o != '0 && gnt_o != prev_g) order.push_back($clog2(gnt_o));
      prev_g = gnt_o;
      for (int k = 0; k < N; k++) begin
        if (m_ack_o[k]) begin
          acked[k] = 1; nacks++;
          checks++;
          if (m_dat_o !== 32'hA5A5_0000 + k) begin
            errors++;
            $display("FAIL rotation_rdata master %0d: got %h expected %h", k, m_dat_o, 32'hA5A5_0000 + k);
          end
        end
      end
      tick();
    end
    checks++;
    if (nacks != 5 || order.size() != 5) begin
      errors++;
      $display("FAIL rotation_progress: acks=%0d grants=%0d expected 5 and 5", nacks, order.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (order[j] != j % N) begin
          errors++;
          $display("FAIL rotation_order grant %0d: got master %0d expected %0d", j, order[j], j % N);
        end
      end
    end
    drive_idle(); tick(); tick();
  endtask

  task automatic test_single_master();
    int acks = 0;
    bit stray = 0;
    drive_idle();
    set_master(0, 1'b1, 10'h010, 4'hF, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      m_cyc[0] = (i <= 6); m_stb[0] = (i <= 6);
      s_ack = (i == 3 || i == 6);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (gnt_o !== 4'b0000) begin
          errors++; $display("FAIL single_no_early_grant: gnt=%b expected 0000", gnt_o);
        end
      end
      if (i == 1) begin
        checks++;
        if (gnt_o !== 4'b0001 || s_adr_o !== 10'h010 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 4'hF) begin
          errors++;
          $display("FAIL single_grant: gnt=%b adr=%h dat=%h sel=%h expected 0001 010 deadbeef f",
                   gnt_o, s_adr_o, s_dat_o, s_sel_o);
        end
      end
      acks += int'(m_ack_o[0]);
      if (m_ack_o[3:1] != 3'b000) stray = 1;
      tick();
    end
    checks++;
    if (acks != 2 || stray) begin
      errors++;
      $display("FAIL single_acks: ack0 pulses=%0d other-ack=%0b expected 2 and 0", acks, stray);
    end
    drive_idle(); tick();
  endtask

  task automatic test_lock();
    int acks = 0;
    drive_idle();
    set_master(2, 1'b1, 10'h155, 4'h3, 32'h1234_5678);
    set_master(1, 1'b0, 10'h0AA, 4'hC, 32'h0);
    for (int i = 0; i < 14; i++) begin
      m_cyc[2] = (i <= 10); m_stb[2] = (i <= 10);
      m_cyc[1] = (i >= 2);
      s_ack = (i >= 2 && i <= 10 && i % 2 == 0);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lock_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (m_ack_o[2]) begin
        acks++;
        checks++;
        if (gnt_o !== 4'b0100) begin
          errors++; $display("FAIL lock_hold beat %0d: gnt=%b expected 0100", acks, gnt_o);
        end
      end
      if (i == 12 || i == 13) begin
        checks++;
        if (gnt_o !== ((i == 12) ? 4'b0000 : 4'b0010)) begin
          errors++;
          $display("FAIL lock_handover cycle %0d: gnt=%b expected %b", i, gnt_o, (i == 12) ? 4'b0000 : 4'b0010);
        end
      end
      tick();
    end
    checks++;
    if (acks != 5) begin
      errors++; $display("FAIL lock_beats: got %0d acks expected 5", acks);
    end
    drive_idle(); tick(); tick();
  endtask

  task automatic test_timeout();
    drive_idle();
    set_master(3, 1'b0, 10'h3FF, 4'hF, 32'h0);
    for (int i = 0; i < 13; i++) begin
      logic [3:0] want_err;
      logic want_cyc;
      m_cyc[3] = (i <= 10); m_stb[3] = (i <= 10);
      s_ack = (i == 10);
      want_err = (i == 9) ? 4'b1000 : 4'b0000;
      want_cyc = (i >= 1 && i <= 8);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      checks++;
      if (m_err_o !== want_err || s_cyc_o !== want_cyc || m_ack_o !== 4'b0000) begin
        errors++;
        $display("FAIL timeout_abort cycle %0d: err=%b s_cyc=%b ack=%b expected %b %b 0000",
                 i, m_err_o, s_cyc_o, m_ack_o, want_err, want_cyc);
      end
      if (i == 10 || i == 12) begin
        checks++;
        if (gnt_o !== ((i == 10) ? 4'b1000 : 4'b0000)) begin
          errors++;
          $display("FAIL timeout_grant cycle %0d: gnt=%b expected %b", i, gnt_o, (i == 10) ? 4'b1000 : 4'b0000);
        end
      end
      tick();
    end
    drive_idle(); tick();
  endtask

  task automatic test_err_at_timeout();
    int pulses = 0;
    drive_idle();
    set_master(0, 1'b1, 10'h020, 4'h1, 32'hCAFE_F00D);
    for (int i = 0; i < 13; i++) begin
      m_cyc[0] = (i <= 11); m_stb[0] = (i <= 11);
      s_err = (i == 8);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL errtmo_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (m_err_o != '0) pulses++;
      if (i == 8 || (i >= 9 && i <= 11)) begin
        checks++;
        if (m_err_o !== ((i == 8) ? 4'b0001 : 4'b0000) || s_cyc_o !== 1'b1 || gnt_o !== 4'b0001) begin
          errors++;
          $display("FAIL errtmo_no_abort cycle %0d: err=%b s_cyc=%b gnt=%b", i, m_err_o, s_cyc_o, gnt_o);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL errtmo_pulses: got %0d err cycles expected 1", pulses);
    end
    drive_idle(); tick();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    set_master(1, 1'b1, 10'h111, 4'hF, 32'h5555_AAAA);
    m_cyc[1] = 1; m_stb[1] = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i < 2) tick();
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: gnt=%b s_cyc=%b s_stb=%b expected 0000 0 0", gnt_o, s_cyc_o, s_stb_o);
    end
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    tick();
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[2] = 1; m_stb[2] = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== ((i == 0) ? 4'b0000 : 4'b0001) || act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_priority cycle %0d: gnt=%b bus %h expected bus %h", i, gnt_o, act_vec, exp_vec());
      end
      tick();
    end
    drive_idle(); tick(); tick();
  endtask

  task automatic test_random();
    bit dead = 0;
    drive_idle();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!m_cyc[k]) m_cyc[k] = ($urandom_range(0, 3) == 0);
        else           m_cyc[k] = ($urandom_range(0, 7) != 0);
        m_stb[k] = m_cyc[k] & 1'($urandom_range(0, 1));
        m_we[k]  = 1'($urandom_range(0, 1));
      end
      m_adr  = 40'({$urandom(), $urandom()});
      m_sel  = 16'($urandom());
      m_wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 19) == 0) dead = ~dead;
      s_ack = !dead && ($urandom_range(0, 2) == 0);
      s_err = !dead && ($urandom_range(0, 15) == 0);
      s_dat = $urandom();
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_bus cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      tick();
    end
    drive_idle(); tick();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    model_reset();
    test_reset();
    test_rotation();
    test_single_master();
    test_lock();
    test_timeout();
    test_err_at_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
